// File: rtl/tft_timing_gen.sv
// tft_timing_gen
//   Parametrised TFT raster timing generator with an early pixel-request
//   front end and PWM backlight. Counters run on sys_clk; pixel requests are
//   issued PIX_LEAD clocks ahead of tft_de so a pipelined pixel generator
//   can return pix_data in time for the matching DE clock.
//
// Ports
//   sys_clk, sys_rst    pixel clock, synchronous active-high reset
//   tft_en              run request, acted on only at frame boundaries
//   bl_duty             backlight duty (0 = off, 255 = always on)
//   pix_data            generator pixel, valid PIX_LEAD-1 clocks after pix_req
//   pix_req/pix_x/pix_y pixel request and active-area coordinates (3FF when idle)
//   rgb_tft, tft_de     registered panel data and data enable
//   hsync, vsync        syncs, active level SYNC_POL
//   tft_clk             pass-through of sys_clk
//   tft_bl              backlight PWM
//   frame_start         one-clock pulse per frame, aligned with pix_req timing
module tft_timing_gen #(
    parameter int   H_SYNC   = 41,
    parameter int   H_BACK   = 2,
    parameter int   H_VALID  = 480,
    parameter int   H_FRONT  = 2,
    parameter int   V_SYNC   = 10,
    parameter int   V_BACK   = 2,
    parameter int   V_VALID  = 272,
    parameter int   V_FRONT  = 2,
    parameter int   PIX_LEAD = 2,
    parameter logic SYNC_POL = 1'b0,
    parameter int   DATA_W   = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              tft_en,
    input  logic [7:0]        bl_duty,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_req,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y,
    output logic [DATA_W-1:0] rgb_tft,
    output logic              hsync,
    output logic              vsync,
    output logic              tft_de,
    output logic              tft_clk,
    output logic              tft_bl,
    output logic              frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_E  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_SYNC + H_BACK + H_VALID);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_SYNC + V_BACK + V_VALID);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;

    logic              run, act_d, hs_act_d, vs_act_d, fs_d;
    logic [9:0]        pix_x_d, pix_y_d;

    logic              pix_req_q, frame_start_q;
    logic [9:0]        pix_x_q, pix_y_q;
    // Sync/DE delay line; stage 0 is registered alongside pix_req.
    logic [PIX_LEAD-1:0] de_pipe_q, hs_pipe_q, vs_pipe_q;
    logic              tft_de_q, hsync_q, vsync_q;
    logic [DATA_W-1:0] rgb_q;

    logic [7:0]        pwm_q, duty_q;
    logic              bl_q;

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        unique case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (tft_en) state_d = RUN;
            end
            RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_d = '0;
                        // tft_en only matters on the very last clock of a frame.
                        if (!tft_en) state_d = IDLE;
                    end else begin
                        v_cnt_d = v_cnt_q + 1'b1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        run      = (state_q == RUN);
        hs_act_d = run && (h_cnt_q < H_SYNC_E);
        vs_act_d = run && (v_cnt_q < V_SYNC_E);
        act_d    = run && (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END)
                       && (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
        fs_d     = run && (h_cnt_q == '0) && (v_cnt_q == '0);
        pix_x_d  = act_d ? 10'(h_cnt_q - H_ACT_BEG) : 10'h3FF;
        pix_y_d  = act_d ? 10'(v_cnt_q - V_ACT_BEG) : 10'h3FF;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_req_q     <= 1'b0;
            pix_x_q       <= 10'h3FF;
            pix_y_q       <= 10'h3FF;
            frame_start_q <= 1'b0;
            de_pipe_q     <= '0;
            hs_pipe_q     <= '0;
            vs_pipe_q     <= '0;
            tft_de_q      <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            pwm_q         <= '0;
            duty_q        <= '0;
            bl_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_req_q     <= act_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= fs_d;

            de_pipe_q[0]  <= act_d;
            hs_pipe_q[0]  <= hs_act_d;
            vs_pipe_q[0]  <= vs_act_d;
            for (int i = 1; i < PIX_LEAD; i++) begin
                de_pipe_q[i] <= de_pipe_q[i-1];
                hs_pipe_q[i] <= hs_pipe_q[i-1];
                vs_pipe_q[i] <= vs_pipe_q[i-1];
            end

            // Last stage: pix_data for this pixel is valid on this edge.
            tft_de_q <= de_pipe_q[PIX_LEAD-1];
            rgb_q    <= de_pipe_q[PIX_LEAD-1] ? pix_data : '0;
            hsync_q  <= hs_pipe_q[PIX_LEAD-1] ? SYNC_POL : ~SYNC_POL;
            vsync_q  <= vs_pipe_q[PIX_LEAD-1] ? SYNC_POL : ~SYNC_POL;

            // Duty is only picked up at the period wrap so a change never
            // splits a PWM period.
            bl_q  <= (duty_q == 8'hFF) || (pwm_q < duty_q);
            if (pwm_q == 8'hFF) duty_q <= bl_duty;
            pwm_q <= pwm_q + 1'b1;
        end
    end

    assign pix_req     = pix_req_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign tft_de      = tft_de_q;
    assign rgb_tft     = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign tft_bl      = bl_q;
    assign tft_clk     = sys_clk;
endmodule

// File: tb/tb_tft_timing_gen.sv
// Bench for tft_timing_gen on a small panel geometry. Expected frame_start,
// sync-edge and DE events are pushed per frame from the raster arithmetic;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_tft_timing_gen;
    localparam int HS = 4, HB = 3, HV = 16, HF = 2;
    localparam int VS = 2, VB = 2, VV = 6, VF = 1;
    localparam int PL = 3, DW = 16;
    localparam logic SP  = 1'b1;
    localparam logic NSP = ~SP;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FT = HT * VT;

    logic          sys_clk = 1'b0, sys_rst = 1'b1, tft_en = 1'b0;
    logic [7:0]    bl_duty = 8'd0;
    logic [DW-1:0] pix_data;
    logic          pix_req, hsync, vsync, tft_de, tft_clk, tft_bl, frame_start;
    logic [9:0]    pix_x, pix_y;
    logic [DW-1:0] rgb_tft;

    always #5 sys_clk = ~sys_clk;

    tft_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .PIX_LEAD(PL), .SYNC_POL(SP), .DATA_W(DW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tft_en(tft_en), .bl_duty(bl_duty),
        .pix_data(pix_data), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .rgb_tft(rgb_tft), .hsync(hsync), .vsync(vsync), .tft_de(tft_de),
        .tft_clk(tft_clk), .tft_bl(tft_bl), .frame_start(frame_start)
    );

    // Pixel generator with PL-1 clocks of latency returning its coordinates.
    logic [DW-1:0] gen_q [PL-1];
    always @(posedge sys_clk) begin
        gen_q[0] <= {pix_y[5:0], pix_x};
        for (int i = 1; i < PL - 1; i++) gen_q[i] <= gen_q[i-1];
    end
    assign pix_data = gen_q[PL-2];

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct { int cyc; int data; } de_exp_t;
    de_exp_t de_q[$];
    int      fs_q[$], hs_q[$], vs_q[$];

    task automatic push_frame(input int t0);
        de_exp_t e;
        fs_q.push_back(t0);
        vs_q.push_back(t0 + PL);
        for (int v = 0; v < VT; v++) hs_q.push_back(t0 + PL + v * HT);
        for (int y = 0; y < VV; y++)
            for (int x = 0; x < HV; x++) begin
                e.cyc  = t0 + (VS + VB + y) * HT + HS + HB + x + PL;
                e.data = (y % 64) * 1024 + x;
                de_q.push_back(e);
            end
    endtask

    // Monitor
    bit mon_en = 1'b0, hs_prev = 1'b0, vs_prev = 1'b0;
    int hs_rise = 0, vs_rise = 0;
    always @(negedge sys_clk) begin
        bit hs_a, vs_a;
        de_exp_t e;
        int t;
        hs_a = (hsync == SP);
        vs_a = (vsync == SP);
        if (!mon_en) begin
            hs_prev = 1'b0;
            vs_prev = 1'b0;
        end else begin
            if (frame_start) begin
                if (fs_q.size() == 0) chk("frame_start_unexpected", 1, 0);
                else begin t = fs_q.pop_front(); chk("frame_start_cyc", cyc, t); end
            end
            if (tft_de) begin
                if (de_q.size() == 0) chk("de_unexpected", 1, 0);
                else begin
                    e = de_q.pop_front();
                    chk("de_cyc", cyc, e.cyc);
                    chk("de_rgb", int'(rgb_tft), e.data);
                end
            end else if (rgb_tft != '0) chk("rgb_outside_de", int'(rgb_tft), 0);
            if (!pix_req && (pix_x != 10'h3FF || pix_y != 10'h3FF))
                chk("pix_xy_idle", int'({pix_y, pix_x}), 20'hFFFFF);
            if (hs_a && !hs_prev) begin
                hs_rise = cyc;
                if (hs_q.size() == 0) chk("hsync_unexpected", 1, 0);
                else begin t = hs_q.pop_front(); chk("hsync_rise_cyc", cyc, t); end
            end
            if (!hs_a && hs_prev) chk("hsync_width", cyc - hs_rise, HS);
            if (vs_a && !vs_prev) begin
                vs_rise = cyc;
                if (vs_q.size() == 0) chk("vsync_unexpected", 1, 0);
                else begin t = vs_q.pop_front(); chk("vsync_rise_cyc", cyc, t); end
            end
            if (!vs_a && vs_prev) chk("vsync_width", cyc - vs_rise, VS * HT);
            hs_prev = hs_a;
            vs_prev = vs_a;
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) begin @(posedge sys_clk); #1; end
    endtask

    task automatic start_run(output int t0);
        @(posedge sys_clk); #1;
        tft_en = 1'b1;
        t0 = cyc + 2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pix_req"}, int'(pix_req), 0);
        chk({tag, "_pix_x"}, int'(pix_x), 10'h3FF);
        chk({tag, "_pix_y"}, int'(pix_y), 10'h3FF);
        chk({tag, "_rgb"}, int'(rgb_tft), 0);
        chk({tag, "_de"}, int'(tft_de), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
        chk({tag, "_bl"}, int'(tft_bl), 0);
        chk({tag, "_hsync"}, int'(hsync), int'(NSP));
        chk({tag, "_vsync"}, int'(vsync), int'(NSP));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_hsync"}, int'(hsync), int'(NSP));
        chk({tag, "_vsync"}, int'(vsync), int'(NSP));
        chk({tag, "_de"}, int'(tft_de), 0);
        chk({tag, "_pix_req"}, int'(pix_req), 0);
        chk({tag, "_de_left"}, de_q.size(), 0);
        chk({tag, "_fs_left"}, fs_q.size(), 0);
        chk({tag, "_hs_left"}, hs_q.size(), 0);
        chk({tag, "_vs_left"}, vs_q.size(), 0);
    endtask

    task automatic count_bl(input int n, output int hi);
        hi = 0;
        repeat (n) begin @(negedge sys_clk); if (tft_bl) hi++; end
    endtask

    // Length of the next complete high run of tft_bl; optionally switches the
    // duty to 192 part way through that run.
    task automatic meas_run(input bit change, output int len);
        bit prev, seen;
        seen = 1'b0;
        len  = 0;
        @(negedge sys_clk);
        prev = tft_bl;
        for (int n = 0; n < 600; n++) begin
            @(negedge sys_clk);
            if (tft_bl && !prev) begin seen = 1'b1; break; end
            prev = tft_bl;
        end
        chk("bl_rise_seen", int'(seen), 1);
        if (seen) begin
            len = 1;
            for (int n = 0; n < 300; n++) begin
                @(negedge sys_clk);
                if (!tft_bl) break;
                len++;
                if (change && len == 20) bl_duty = 8'd192;
            end
        end
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog actual timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int t0, hi, len, d;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_reset("reset");
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        mon_en  = 1'b1;

        // Backlight, while idle; random duties first, then the fixed cases.
        repeat (2) begin
            d = $urandom_range(1, 254);
            bl_duty = 8'(d);
            repeat (600) @(posedge sys_clk);
            count_bl(256, hi);
            chk("bl_rand_duty", hi, d);
        end
        bl_duty = 8'd64;
        repeat (600) @(posedge sys_clk);
        count_bl(256, hi);
        chk("bl_duty64", hi, 64);
        meas_run(1'b1, len);
        chk("bl_run_old_duty", len, 64);
        meas_run(1'b0, len);
        chk("bl_run_new_duty", len, 192);
        bl_duty = 8'd0;
        repeat (600) @(posedge sys_clk);
        count_bl(256, hi);
        chk("bl_duty0", hi, 0);
        bl_duty = 8'd255;
        repeat (600) @(posedge sys_clk);
        count_bl(256, hi);
        chk("bl_duty255", hi, 256);
        bl_duty = 8'd128;

        // Two back-to-back frames, enable dropped in line 3 of the second.
        start_run(t0);
        push_frame(t0);
        push_frame(t0 + FT);
        wait_cyc(t0 + FT + 3 * HT + $urandom_range(0, HT - 1));
        tft_en = 1'b0;
        wait_cyc(t0 + 2 * FT + PL + 4);
        chk_idle("idle1");
        repeat (30) @(posedge sys_clk);

        // Enable low mid-frame but high again on the frame's last clock.
        start_run(t0);
        push_frame(t0);
        wait_cyc(t0 + 2 * HT);
        tft_en = 1'b0;
        wait_cyc(t0 + FT - 2);
        tft_en = 1'b1;
        push_frame(t0 + FT);
        wait_cyc(t0 + FT + HT);
        tft_en = 1'b0;
        wait_cyc(t0 + 2 * FT + PL + 4);
        chk_idle("idle2");
        repeat (17) @(posedge sys_clk);

        // Reset in the middle of the active area.
        start_run(t0);
        push_frame(t0);
        wait_cyc(t0 + (VS + VB + 2) * HT + HS + HB + $urandom_range(2, HV - 2));
        mon_en = 1'b0;
        de_q.delete(); fs_q.delete(); hs_q.delete(); vs_q.delete();
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        chk_reset("midrst");
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        t0 = cyc + 2;
        mon_en = 1'b1;
        push_frame(t0);
        wait_cyc(t0 + 2 * HT);
        tft_en = 1'b0;
        wait_cyc(t0 + FT + PL + 4);
        chk_idle("idle3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tft_timing_gen.md
# tft_timing_gen

Parametrised TFT timing generator and pixel-fetch front end, the next generation of the team's fixed 480x272 TFT controller. It runs from the single pixel clock produced by the PLL. It generates hsync, vsync and data-enable for any panel geometry, and issues pixel requests early so that pipelined pixel generators (character/picture ROM lookups, DHT11 value overlays) land on the correct pixel. It adds frame-boundary start/stop and PWM backlight dimming.

## Interface
- H_SYNC, 41, hsync pulse width (clocks)
- H_BACK, 2, horizontal back porch
- H_VALID, 480, active pixels per line
- H_FRONT, 2, horizontal front porch
- V_SYNC, 10, vsync pulse width (lines)
- V_BACK, 2, vertical back porch
- V_VALID, 272, active lines
- V_FRONT, 2, vertical front porch
- PIX_LEAD, 2, clocks from pix_req to tft_de for the same pixel; legal range 1..8, and ≤ H_SYNC+H_BACK
- SYNC_POL, 1'b0, active level of hsync/vsync (0 = active-low)
- DATA_W, 16, pixel width (RGB565 default)
- sys_clk  in  1  pixel clock (9 MHz); all logic on its rising edge
- sys_rst  in  1  synchronous, active-high reset
- tft_en  in  1  run request; sampled only at frame boundaries
- bl_duty  in  8  backlight PWM duty
- pix_data  in  DATA_W  pixel from generator, valid PIX_LEAD-1 clocks after pix_req
- pix_req  out  1  pixel request
- pix_x  out  10  active-area X of requested pixel; 10'h3FF when pix_req=0
- pix_y  out  10  active-area Y of requested pixel; 10'h3FF when pix_req=0
- rgb_tft  out  DATA_W  registered pixel to panel; 0 outside active area
- hsync  out  1  line sync
- vsync  out  1  frame sync
- tft_de  out  1  data enable
- tft_clk  out  1  equals sys_clk (pass-through)
- tft_bl  out  1  backlight PWM
- frame_start  out  1  one-clock pulse at the start of each frame

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT (525 default). V_TOTAL = V_SYNC+V_BACK+V_VALID+V_FRONT (286 default).
- Counters: h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h wrap, 0..V_TOTAL-1, and wraps to 0. Both are held at 0 while idle.
- Run state machine, two states:
  - IDLE → RUN when tft_en=1 (the counters are at 0,0).
  - RUN → IDLE on the last clock of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) if tft_en=0 on that clock; otherwise RUN continues.
  - Deasserting tft_en mid-frame never truncates a frame.
- Sync: hsync is active for h_cnt < H_SYNC. vsync is active for v_cnt < V_SYNC. Both are inactive in IDLE.
- Active window: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID), in RUN only.
  - pix_x = h_cnt-(H_SYNC+H_BACK).
  - pix_y = v_cnt-(V_SYNC+V_BACK).
- frame_start pulses on the clock where h_cnt=0, v_cnt=0 in RUN.
- Backlight: free-running 8-bit pwm_cnt, running in IDLE as well.
  - bl_duty=0: tft_bl=0.
  - bl_duty=255: tft_bl=1 constantly.
  - Otherwise tft_bl = (pwm_cnt < bl_duty).
  - bl_duty is latched at pwm_cnt=255, so duty changes are glitch-free.

## Timing
- Reset values:
  - Counters 0, state IDLE, pwm_cnt 0, latched duty 0.
  - pix_req=0, pix_x=pix_y=10'h3FF, rgb_tft=0, tft_de=0, frame_start=0, tft_bl=0.
  - hsync=vsync=~SYNC_POL.
- All outputs except tft_clk are registered. A counter value appears on pix_req/pix_x/pix_y/frame_start one clock later.
- hsync, vsync and tft_de are delayed a further PIX_LEAD clocks relative to pix_req. Sync-to-DE alignment is therefore identical to an undelayed generator.
- The generator returns pix_data at req+PIX_LEAD-1. rgb_tft registers pix_data gated by the delayed DE. rgb_tft and tft_de change on the same edge, PIX_LEAD clocks after pix_req.
- Lines wrap seamlessly; there is no gap clock between frames in RUN.
- RUN→IDLE: the delay pipeline drains normally, so the last-frame DE/sync outputs complete.
- Reset mid-frame: on the next edge all outputs return to their reset values and the pipeline is flushed.
- Simultaneous events: tft_en rising on the same clock as the frame's last clock keeps RUN.

## Test plan
- Reset, tft_en=1, default params, PIX_LEAD=2:
  - first frame_start 2 clocks after reset release.
  - hsync low for 41 clocks every 525.
  - vsync low for 10 lines.
  - frame period 150150 clocks.
- Model generator with 1-clock latency returning {pix_y[5:0],pix_x[9:0]}:
  - every tft_de=1 clock has rgb_tft equal to its own coordinates.
  - exactly 480 DE clocks per line and 272 DE lines per frame.
  - rgb_tft=0 whenever tft_de=0.
- Drop tft_en at line 100 of a frame: the frame completes with 272 DE lines, then idle with hsync/vsync inactive. Reassert: frame_start 2 clocks later.
- bl_duty=64: tft_bl high 64 of every 256 clocks. Change to 192 mid-period: the new duty takes effect only after pwm_cnt wraps. Check duties 0 and 255: constant 0 and 1.
- Assert sys_rst at pixel (200,50): next edge all outputs equal reset values. After release the timing restarts at frame_start.
- Params H_VALID=800, V_VALID=480, PIX_LEAD=5, SYNC_POL=1: active-high syncs; 800x480 DE; pix_req leads tft_de by 5 clocks.
